eq_coeff_ctrl: RTL and testbench

Double-buffered coefficient controller for the multi-channel biquad `equalizer`. It supplies the equalizer's registered coefficient read port, and accepts host writes into a shadow bank. On a host commit, it swaps the shadow and active banks at the next frame boundary, so all channels and bands change coefficients together without glitches. It sits between the configuration bus and the equalizer, and replaces the fixed coefficient ROM/mux used in benches.

---
 rtl/eq_coeff_ctrl_if.sv | 37 +++
 rtl/eq_coeff_ctrl.sv | 145 ++++++++++++++
 tb/tb_eq_coeff_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_coeff_ctrl_if.sv
// Configuration, equalizer read port and stream-monitor signals of the
// double-buffered equalizer coefficient controller.
interface eq_coeff_ctrl_if #(
  parameter int NR_CHANNELS    = 3,
  parameter int NR_EQ_BANDS    = 8,
  parameter int EQ_COEFF_WIDTH = 32
);
  localparam int NR_EQ_COEFF         = NR_CHANNELS * NR_EQ_BANDS * 5;
  localparam int EQ_COEFF_ADDR_WIDTH = $clog2(NR_EQ_COEFF);
  localparam int CHANNEL_WIDTH       = $clog2(NR_CHANNELS);

  logic [EQ_COEFF_ADDR_WIDTH-1:0] eq_coeff_addr;
  logic [EQ_COEFF_WIDTH-1:0]      eq_coeff;
  logic                           s_tvalid;
  logic                           s_tready;
  logic [CHANNEL_WIDTH-1:0]       s_tid;
  logic                           cfg_wr;
  logic [EQ_COEFF_ADDR_WIDTH-1:0] cfg_addr;
  logic [EQ_COEFF_WIDTH-1:0]      cfg_data;
  logic                           cfg_commit;
  logic                           cfg_busy;
  logic                           cfg_drop;
  logic                           swap_done;
  logic                           bank_sel;

  modport master (
    output eq_coeff_addr, s_tvalid, s_tready, s_tid,
           cfg_wr, cfg_addr, cfg_data, cfg_commit,
    input  eq_coeff, cfg_busy, cfg_drop, swap_done, bank_sel
  );

  modport slave (
    input  eq_coeff_addr, s_tvalid, s_tready, s_tid,
           cfg_wr, cfg_addr, cfg_data, cfg_commit,
    output eq_coeff, cfg_busy, cfg_drop, swap_done, bank_sel
  );
endinterface

// File: rtl/eq_coeff_ctrl.sv
// Double-buffered biquad coefficient store: host writes a shadow bank, a commit
// swaps banks on the next tid-0 stream acceptance, then the new active bank is
// copied back into the shadow.
module eq_coeff_ctrl #(
  parameter int NR_CHANNELS    = 3,
  parameter int NR_EQ_BANDS    = 8,
  parameter int EQ_COEFF_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  eq_coeff_ctrl_if.slave bus
);
  localparam int NR_EQ_COEFF = NR_CHANNELS * NR_EQ_BANDS * 5;
  localparam int AW          = $clog2(NR_EQ_COEFF);
  localparam int W           = EQ_COEFF_WIDTH;
  localparam logic [W-1:0]  UNITY = W'(1) << (W - 4);
  localparam logic [AW-1:0] LAST  = AW'(NR_EQ_COEFF - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PENDING, ST_COPY} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          bank_sel_q, bank_sel_d;
  logic          swap_done_q, swap_done_d;
  logic          cfg_drop_q, cfg_drop_d;
  logic [W-1:0]  eq_coeff_q, eq_coeff_d;

  logic [W-1:0]  bank0_q [NR_EQ_COEFF];
  logic [W-1:0]  bank1_q [NR_EQ_COEFF];

  logic          wr_en0, wr_en1;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          busy, boundary, eq_addr_ok, cfg_addr_ok;

  // b0 of every band is unity, all other taps zero: a pass-through filter.
  function automatic logic [W-1:0] unity_at(input logic [AW-1:0] a);
    return ((a % AW'(5)) == '0) ? UNITY : '0;
  endfunction

  function automatic logic [W-1:0] active_rd(input logic [AW-1:0] a, input logic sel);
    return sel ? bank1_q[a] : bank0_q[a];
  endfunction

  assign busy        = (state_q != ST_IDLE);
  assign boundary    = bus.s_tvalid & bus.s_tready & (bus.s_tid == '0);
  assign eq_addr_ok  = int'(bus.eq_coeff_addr) < NR_EQ_COEFF;
  assign cfg_addr_ok = int'(bus.cfg_addr) < NR_EQ_COEFF;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value held and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_sel_d  = bank_sel_q;
    swap_done_d = 1'b0;
    wr_en0      = 1'b0;
    wr_en1      = 1'b0;
    wr_addr     = cnt_q;
    wr_data     = '0;

    cfg_drop_d = ((bus.cfg_wr | bus.cfg_commit) & busy) |
                 (bus.cfg_wr & ~busy & ~cfg_addr_ok);

    if (!eq_addr_ok)             eq_coeff_d = '0;
    else if (state_q == ST_INIT) eq_coeff_d = unity_at(bus.eq_coeff_addr);
    else                         eq_coeff_d = active_rd(bus.eq_coeff_addr, bank_sel_q);

    case (state_q)
      ST_INIT: begin
        wr_en0  = 1'b1;
        wr_en1  = 1'b1;
        wr_data = unity_at(cnt_q);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.cfg_wr && cfg_addr_ok) begin
          wr_en0  = bank_sel_q;
          wr_en1  = ~bank_sel_q;
          wr_addr = bus.cfg_addr;
          wr_data = bus.cfg_data;
        end
        if (bus.cfg_commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (boundary) begin
          bank_sel_d  = ~bank_sel_q;
          swap_done_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_COPY;
        end
      end
      ST_COPY: begin
        // bank_sel_q already names the new active bank; refresh the shadow from it.
        wr_en0  = bank_sel_q;
        wr_en1  = ~bank_sel_q;
        wr_data = active_rd(cnt_q, bank_sel_q);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      bank_sel_q  <= 1'b0;
      swap_done_q <= 1'b0;
      cfg_drop_q  <= 1'b0;
      eq_coeff_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bank_sel_q  <= bank_sel_d;
      swap_done_q <= swap_done_d;
      cfg_drop_q  <= cfg_drop_d;
      eq_coeff_q  <= eq_coeff_d;
    end
  end

  // NOTE: the banks carry no reset so they map onto RAM; INIT fills them.
  always_ff @(posedge clk) begin
    if (wr_en0) bank0_q[wr_addr] <= wr_data;
    if (wr_en1) bank1_q[wr_addr] <= wr_data;
  end

  assign bus.eq_coeff  = eq_coeff_q;
  assign bus.cfg_busy  = busy;
  assign bus.cfg_drop  = cfg_drop_q;
  assign bus.swap_done = swap_done_q;
  assign bus.bank_sel  = bank_sel_q;
endmodule

// File: tb/tb_eq_coeff_ctrl.sv
// Directed bench for eq_coeff_ctrl: a bank-level reference model checked every
// cycle, plus hand-computed expectations along the commit/swap scenarios.
module tb_eq_coeff_ctrl;
  localparam int N = 120;
  localparam logic [31:0] ONE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eq_coeff_ctrl_if bus_if ();
  eq_coeff_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

  int checks = 0;
  int errors = 0;
  int swap_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: banks as plain arrays, init and copy treated as instant
  // content changes that merely keep the block busy for N cycles.
  logic [31:0] m_bank [2][N];
  int          m_act, m_init_left, m_copy_left;
  bit          m_pending, m_started;
  logic [31:0] e_eq;
  bit          e_drop, e_swap;

  function automatic logic [31:0] unity(input int a);
    return (a % 5 == 0) ? ONE : 32'h0;
  endfunction

  function automatic bit m_busy();
    return (m_init_left > 0) || m_pending || (m_copy_left > 0);
  endfunction

  always @(posedge clk) begin
    int a;
    bit was_busy;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_bank[0][i] = unity(i);
        m_bank[1][i] = unity(i);
      end
      m_act = 0; m_init_left = N; m_copy_left = 0; m_pending = 0;
      e_eq = 32'h0; e_drop = 0; e_swap = 0;
      m_started = 1;
    end else begin
      a = int'(bus_if.eq_coeff_addr);
      e_eq = (a < N) ? m_bank[m_act][a] : 32'h0;
      was_busy = m_busy();
      e_swap = 0;
      e_drop = (bus_if.cfg_wr && (was_busy || int'(bus_if.cfg_addr) >= N)) ||
               (bus_if.cfg_commit && was_busy);
      if (m_init_left > 0) begin
        m_init_left--;
      end else if (m_pending) begin
        if (bus_if.s_tvalid && bus_if.s_tready && bus_if.s_tid == 2'd0) begin
          m_act = 1 - m_act;
          for (int i = 0; i < N; i++) m_bank[1 - m_act][i] = m_bank[m_act][i];
          m_pending = 0;
          m_copy_left = N;
          e_swap = 1;
        end
      end else if (m_copy_left > 0) begin
        m_copy_left--;
      end else begin
        if (bus_if.cfg_wr && int'(bus_if.cfg_addr) < N)
          m_bank[1 - m_act][int'(bus_if.cfg_addr)] = bus_if.cfg_data;
        if (bus_if.cfg_commit) m_pending = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("eq_coeff", bus_if.eq_coeff, e_eq);
      check("cfg_busy", 32'(bus_if.cfg_busy), 32'(m_busy()));
      check("cfg_drop", 32'(bus_if.cfg_drop), 32'(e_drop));
      check("swap_done", 32'(bus_if.swap_done), 32'(e_swap));
      check("bank_sel", 32'(bus_if.bank_sel), 32'(m_act));
    end
    if (bus_if.swap_done === 1'b1) swap_cnt++;
  end

  task automatic beat(input bit v, input bit r, input int tid);
    bus_if.s_tvalid = v;
    bus_if.s_tready = r;
    bus_if.s_tid    = 2'(tid);
  endtask

  task automatic rd_check(input string name, input int a, input logic [31:0] exp);
    bus_if.eq_coeff_addr = 7'(a);
    @(negedge clk);
    check(name, bus_if.eq_coeff, exp);
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d);
    bus_if.cfg_wr = 1'b1; bus_if.cfg_addr = 7'(a); bus_if.cfg_data = d;
    @(negedge clk);
    bus_if.cfg_wr = 1'b0;
  endtask

  task automatic commit();
    bus_if.cfg_commit = 1'b1;
    @(negedge clk);
    bus_if.cfg_commit = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus_if.cfg_busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus_if.cfg_busy), 32'h0);
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1;
    bus_if.eq_coeff_addr = '0;
    bus_if.cfg_wr = 1'b0; bus_if.cfg_addr = '0; bus_if.cfg_data = '0;
    bus_if.cfg_commit = 1'b0;
    beat(0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus_if.cfg_busy), 32'h1);
    check("rst_bank_sel", 32'(bus_if.bank_sel), 32'h0);
    check("rst_eq", bus_if.eq_coeff, 32'h0);
    check("rst_drop", 32'(bus_if.cfg_drop), 32'h0);
    check("rst_swap", 32'(bus_if.swap_done), 32'h0);

    // INIT length and unity reads while it runs
    rst = 1'b0;
    bus_if.eq_coeff_addr = 7'd5;
    n = 0;
    while (bus_if.cfg_busy === 1'b1 && n < 400) begin
      n++;
      if (n == 60) begin
        check("init_rd5", bus_if.eq_coeff, ONE);
        bus_if.eq_coeff_addr = 7'd120;
      end
      if (n == 62) check("init_rd120", bus_if.eq_coeff, 32'h0);
      @(negedge clk);
    end
    check("init_len", 32'(n), 32'd120);
    rd_check("idle_rd0", 0, ONE);
    rd_check("idle_rd1", 1, 32'h0);
    rd_check("idle_rd5", 5, ONE);
    rd_check("idle_rd120", 120, 32'h0);

    // First swap, with a refused write during the copy
    cfg_write(0, 32'h1800_0000);
    commit();
    check("commit_busy", 32'(bus_if.cfg_busy), 32'h1);
    bus_if.eq_coeff_addr = 7'd0;
    beat(1, 0, 0); @(negedge clk);
    beat(1, 1, 1); @(negedge clk);
    beat(1, 1, 2); @(negedge clk);
    check("pre_swap_rd", bus_if.eq_coeff, ONE);
    beat(1, 1, 0); @(negedge clk);
    check("swap_pulse", 32'(bus_if.swap_done), 32'h1);
    check("swap_bank_sel", 32'(bus_if.bank_sel), 32'h1);
    check("swap_edge_rd", bus_if.eq_coeff, ONE);
    beat(0, 0, 0); @(negedge clk);
    check("post_swap_rd", bus_if.eq_coeff, 32'h1800_0000);
    check("swap_single", 32'(bus_if.swap_done), 32'h0);
    n = 1;
    while (bus_if.cfg_busy === 1'b1 && n < 400) begin
      n++;
      if (n == 5) begin
        bus_if.cfg_wr = 1'b1; bus_if.cfg_addr = 7'd2; bus_if.cfg_data = 32'hDEAD_BEEF;
      end
      if (n == 6) begin
        check("copy_drop", 32'(bus_if.cfg_drop), 32'h1);
        bus_if.cfg_wr = 1'b0;
      end
      @(negedge clk);
    end
    check("copy_len", 32'(n), 32'd120);
    check("swap_count", 32'(swap_cnt), 32'd1);

    // Out-of-range write in IDLE
    cfg_write(120, 32'h1234_5678);
    check("oor_drop", 32'(bus_if.cfg_drop), 32'h1);
    @(negedge clk);
    check("oor_drop_end", 32'(bus_if.cfg_drop), 32'h0);

    // Partial update on top of the copied bank
    cfg_write(1, 32'hF000_0000);
    commit();
    beat(1, 1, 0); @(negedge clk);
    check("swap2_bank_sel", 32'(bus_if.bank_sel), 32'h0);
    beat(0, 0, 0);
    wait_idle("swap2_idle");
    rd_check("swap2_rd0", 0, 32'h1800_0000);
    rd_check("swap2_rd1", 1, 32'hF000_0000);
    rd_check("swap2_rd2", 2, 32'h0);

    // Commit coincident with a boundary beat swaps on the following one
    bus_if.cfg_commit = 1'b1;
    beat(1, 1, 0); @(negedge clk);
    bus_if.cfg_commit = 1'b0;
    check("cb_busy", 32'(bus_if.cfg_busy), 32'h1);
    check("cb_no_swap", 32'(bus_if.swap_done), 32'h0);
    beat(1, 1, 1); @(negedge clk);
    check("cb_still_old", 32'(bus_if.bank_sel), 32'h0);
    beat(1, 1, 0); @(negedge clk);
    check("cb_swap", 32'(bus_if.swap_done), 32'h1);
    check("cb_bank_sel", 32'(bus_if.bank_sel), 32'h1);
    beat(0, 0, 0);
    wait_idle("cb_idle");

    // Reset while PENDING discards the commit
    commit();
    @(negedge clk);
    check("pend_busy", 32'(bus_if.cfg_busy), 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_bank_sel", 32'(bus_if.bank_sel), 32'h0);
    rst = 1'b0;
    base = swap_cnt;
    wait_idle("rst2_idle");
    rd_check("rst2_rd0", 0, ONE);
    beat(1, 1, 0);
    repeat (5) @(negedge clk);
    beat(0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst2_no_swap", 32'(swap_cnt), 32'(base));
    check("rst2_bank_sel_end", 32'(bus_if.bank_sel), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
